decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: a fetched instruction is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: the stage accepts the instruction this cycle.
REQ-005 SHALL have port in_instr, input, 32 bits: the raw RV32I instruction word.
REQ-006 SHALL have port in_pc, input, 32 bits: the PC of in_instr.
REQ-007 SHALL have port flush, input, 1 bit: discard all held and incoming instructions.
REQ-008 SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a decoded instruction.
REQ-009 SHALL have port out_ready, input, 1 bit: the execute stage consumes the output this cycle.
REQ-010 SHALL have port out_instr, output, decoded_instr_t: the decoded fields consumed by the ALU.
REQ-011 SHALL have port out_pc, output, 32 bits: the PC that travels with out_instr.

Function
REQ-012 SHALL transfer on in_valid&&in_ready (input side) and on out_valid&&out_ready (output side); no other condition transfers data.
REQ-013 SHALL register the output: an accepted instruction appears on out_* exactly 1 cycle after acceptance when the output register is empty or draining.
REQ-014 SHALL hold a 2-entry buffer (output register plus skid register); in_ready = !skid_valid, driven from a flop with no combinational path from out_ready.
REQ-015 SHALL place an instruction accepted while the output is stalled (out_valid && !out_ready) into the skid register; the skid register moves to the output on the next output transfer; order is strictly FIFO.
REQ-016 SHALL keep out_* stable while out_valid && !out_ready.
REQ-017 SHALL decode fields: opcode=[6:0], rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20].
REQ-018 SHALL, for OP (0110011), set is_r=1, func7=[31:25], imm_i=0.
REQ-019 SHALL, for OP-IMM (0010011) with func3 001/101, set is_r=0, func7=[31:25], imm_i={27'b0,[24:20]}.
REQ-020 SHALL, for OP-IMM with any other func3, set is_r=0, func7=0, imm_i=sign-extended [31:20]. A negative ADDI immediate SHALL NOT set func7 to 0x20.
REQ-021 SHALL set reg_write=1 for legal OP, OP-IMM, LUI, AUIPC, JAL, JALR and LOAD with rd!=0; otherwise reg_write=0.
REQ-022 SHALL set illegal=1 and reg_write=0 for any of: [1:0]!=11; unknown opcode; OP with func7 not in {0x00,0x20}; func7=0x20 with func3 not 000/101; OP-IMM shift with func7 not in {0x00,0x20}, or with 0x20 on func3 001. An illegal instruction still flows through the handshake.
REQ-023 SHALL, when flush=1, clear both entries and out_valid at the next edge, drop any same-cycle input transfer, and have in_ready=1 on the following cycle. Flush takes priority over simultaneous input or output transfers.
REQ-024 SHALL, on simultaneous input and output transfer with only the output register full, load the new instruction straight into the output register.

Reset
REQ-025 SHALL, while rst=1, force out_valid=0 and skid_valid=0, and drive in_ready=0 during reset and 1 from the first cycle after release.
REQ-026 SHALL reset out_instr and out_pc to all-zero, and SHALL abandon any in-flight instruction when reset is asserted mid-operation.

Structure
REQ-027 SHALL use decoded_instr_t (opcode, rd, rs1, rs2, func3, func7, imm_i, is_r, reg_write, illegal) and the opcode constants from the shared decoded_instr package/header; no local redefinition.
REQ-028 SHALL implement decoding as one combinational sub-module, instr_decoder (in_instr to decoded_instr_t), instantiated ahead of the skid buffer.

Verification
REQ-029 SHALL cover: 0xFFF00093 (ADDI x1,x0,-1) -> opcode=0x13, rd=1, func3=0, func7=0, imm_i=0xFFFFFFFF, is_r=0, reg_write=1, 1 cycle later.
REQ-030 SHALL cover: 0x402081B3 (SUB x3,x1,x2) -> is_r=1, func7=0x20, func3=0, rd=3, rs1=1, rs2=2; and 0x4032D293 (SRAI x5,x5,3) -> func7=0x20, func3=5, imm_i=0x3.
REQ-031 SHALL cover: out_ready=0 while 3 instructions are offered -> 2 accepted, in_ready low, third held; then out_ready=1 -> all 3 emerge in order with no loss or duplication.
REQ-032 SHALL cover: flush with both entries full and in_valid=1 -> out_valid=0 next cycle, no flushed instruction ever emerges, in_ready=1 the cycle after.
REQ-033 SHALL cover: 0x00000000 and 0xFE0080B3 -> illegal=1, reg_write=0, out_valid handshake normal.
REQ-034 SHALL cover: rst pulsed asynchronously mid-stream with both entries full -> out_valid=0 immediately, out_instr/out_pc=0, and nothing pre-reset emerges afterwards.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions for the RV32I decode stage.
// Contents:
//   decoded_instr_t : decoded fields handed from decode to the ALU
//   OPC_*           : base opcodes recognised by the decoder
//   imm_i_sext      : sign-extends an I-type immediate
package decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [6:0] FUNC7_BASE = 7'h00;
    localparam logic [6:0] FUNC7_ALT  = 7'h20;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm_i;
        logic        is_r;
        logic        reg_write;
        logic        illegal;
    } decoded_instr_t;

    function automatic logic [31:0] imm_i_sext(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// instr_decoder: purely combinational RV32I field decoder.
// Ports:
//   instr : raw 32-bit instruction word
//   dec   : decoded fields, legality and register-write flag
module instr_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0]    instr,
    output decoded_instr_t dec
);

    logic       bad;
    logic       f7_ok;
    logic       is_shift;
    logic [6:0] f7;
    logic [2:0] f3;

    assign f7       = instr[31:25];
    assign f3       = instr[14:12];
    assign f7_ok    = (f7 == FUNC7_BASE) || (f7 == FUNC7_ALT);
    // func3 001 (SLLI) and 101 (SRLI/SRAI) carry a shamt, not an immediate
    assign is_shift = (instr[13:12] == 2'b01);

    always_comb begin
        dec        = '0;
        bad        = 1'b0;
        dec.opcode = instr[6:0];
        dec.rd     = instr[11:7];
        dec.func3  = f3;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];

        case (instr[6:0])
            OPC_OP: begin
                dec.is_r  = 1'b1;
                dec.func7 = f7;
                bad       = !f7_ok || ((f7 == FUNC7_ALT) && !((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    dec.func7 = f7;
                    dec.imm_i = {27'b0, instr[24:20]};
                    bad       = !f7_ok || ((f7 == FUNC7_ALT) && (f3 == 3'b001));
                end else begin
                    // func7 stays zero so a negative immediate never looks like SUB/SRA
                    dec.imm_i = imm_i_sext(instr[31:20]);
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec.imm_i = imm_i_sext(instr[31:20]);
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                bad = 1'b0;
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        if (instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end

        dec.illegal   = bad;
        dec.reg_write = !bad && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with a registered, two-entry skid-buffered output.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : fetch-side handshake; in_instr/in_pc payload
//   flush               : drop everything held plus any same-cycle input
//   out_valid/out_ready : execute-side handshake; out_instr/out_pc payload
//
// state | meaning
// EMPTY | nothing held
// ONE   | output register valid, skid register empty
// FULL  | output and skid registers both valid, input blocked
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_instr,
    input  logic [31:0]    in_pc,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output decoded_instr_t out_instr,
    output logic [31:0]    out_pc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t     state;
    buf_state_t     state_next;

    decoded_instr_t dec;
    decoded_instr_t skid_instr;
    logic [31:0]    skid_pc;

    logic           in_fire;
    logic           out_fire;
    logic           load_out_from_in;
    logic           load_out_from_skid;
    logic           load_skid;

    instr_decoder u_decoder (
        .instr (in_instr),
        .dec   (dec)
    );

    // in_ready depends only on state (and reset), never on out_ready
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state_next = ONE;
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_next = FULL;
                    end else if (!in_fire && out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: if (out_fire) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready           = (state != FULL) && !rst;
        out_valid          = (state != EMPTY);
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: load_out_from_in = in_fire;
                ONE: begin
                    // draining output plus new input: bypass the skid register
                    load_out_from_in = in_fire && out_fire;
                    load_skid        = in_fire && !out_fire;
                end
                FULL: load_out_from_skid = out_fire;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_instr  <= '0;
            out_pc     <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            if (load_out_from_in) begin
                out_instr <= dec;
                out_pc    <= in_pc;
            end else if (load_out_from_skid) begin
                out_instr <= skid_instr;
                out_pc    <= skid_pc;
            end
            if (load_skid) begin
                skid_instr <= dec;
                skid_pc    <= in_pc;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [31:0]    in_instr = '0;
    logic [31:0]    in_pc = '0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    decoded_instr_t out_instr;
    logic [31:0]    out_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        decoded_instr_t d;
        logic [31:0]    pc;
    } entry_t;

    entry_t      model_q[$];
    logic [31:0] emerged[$];

    decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the ISA rules.
    function automatic decoded_instr_t ref_decode(input logic [31:0] w);
        decoded_instr_t r;
        int  f3, f7, opc;
        bit  known, bad;
        r   = '0;
        opc = int'(w[6:0]);
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        r.opcode = w[6:0];
        r.rd     = w[11:7];
        r.rs1    = w[19:15];
        r.rs2    = w[24:20];
        r.func3  = w[14:12];
        known = (opc == 'h33) || (opc == 'h13) || (opc == 'h37) || (opc == 'h17) ||
                (opc == 'h6F) || (opc == 'h67) || (opc == 'h03);
        bad = (w[1:0] != 2'b11) || !known;
        if (opc == 'h33) begin
            r.is_r  = 1'b1;
            r.func7 = w[31:25];
            if (!(f7 == 0 || f7 == 32)) bad = 1;
            if (f7 == 32 && !(f3 == 0 || f3 == 5)) bad = 1;
        end else if (opc == 'h13 && (f3 == 1 || f3 == 5)) begin
            r.func7 = w[31:25];
            r.imm_i = 32'(int'(w[24:20]));
            if (!(f7 == 0 || f7 == 32)) bad = 1;
            if (f7 == 32 && f3 == 1) bad = 1;
        end else if (opc == 'h13 || opc == 'h67 || opc == 'h03) begin
            r.imm_i = 32'($signed(w[31:20]));
        end
        r.illegal   = bad;
        r.reg_write = !bad && (w[11:7] != 0);
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs [7];
        int          k;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03};
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 7) begin
            w[6:0] = opcs[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end else if (k == 8) begin
            w[1:0] = 2'b11;
        end
        return w;
    endfunction

    // One cycle: called just after a falling edge with inputs already driven.
    task automatic tick();
        logic exp_rdy;
        #1;
        exp_rdy = (model_q.size() < 2);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, model_q.size() > 0);
        if (model_q.size() > 0) begin
            check("out_instr", out_instr, model_q[0].d);
            check("out_pc", out_pc, model_q[0].pc);
        end
        if (flush) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && out_ready) begin
                emerged.push_back(model_q[0].pc);
                void'(model_q.pop_front());
            end
            if (in_valid && exp_rdy) model_q.push_back('{ref_decode(in_instr), in_pc});
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, '0);
        check("rst_out_pc", out_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // ADDI x1,x0,-1
        offer(32'hFFF00093, 32'h100);
        tick();
        in_valid = 1'b0;
        check("addi_valid", out_valid, 1'b1);
        check("addi_opcode", out_instr.opcode, 7'h13);
        check("addi_rd", out_instr.rd, 5'd1);
        check("addi_func3", out_instr.func3, 3'd0);
        check("addi_func7", out_instr.func7, 7'h00);
        check("addi_imm", out_instr.imm_i, 32'hFFFFFFFF);
        check("addi_is_r", out_instr.is_r, 1'b0);
        check("addi_reg_write", out_instr.reg_write, 1'b1);
        check("addi_pc", out_pc, 32'h100);
        tick();

        // SUB x3,x1,x2 then SRAI x5,x5,3
        offer(32'h402081B3, 32'h104);
        tick();
        check("sub_is_r", out_instr.is_r, 1'b1);
        check("sub_func7", out_instr.func7, 7'h20);
        check("sub_func3", out_instr.func3, 3'd0);
        check("sub_rd", out_instr.rd, 5'd3);
        check("sub_rs1", out_instr.rs1, 5'd1);
        check("sub_rs2", out_instr.rs2, 5'd2);
        offer(32'h4032D293, 32'h108);
        tick();
        check("srai_func7", out_instr.func7, 7'h20);
        check("srai_func3", out_instr.func3, 3'd5);
        check("srai_imm", out_instr.imm_i, 32'h3);

        // illegal encodings still flow
        offer(32'h00000000, 32'h10C);
        tick();
        check("zero_valid", out_valid, 1'b1);
        check("zero_illegal", out_instr.illegal, 1'b1);
        check("zero_reg_write", out_instr.reg_write, 1'b0);
        offer(32'hFE0080B3, 32'h110);
        tick();
        check("badf7_valid", out_valid, 1'b1);
        check("badf7_illegal", out_instr.illegal, 1'b1);
        check("badf7_reg_write", out_instr.reg_write, 1'b0);
        in_valid = 1'b0;
        tick();

        // stall with three offered: two taken, third held, then drain in order
        emerged.delete();
        out_ready = 1'b0;
        offer(32'h00100113, 32'h200);
        tick();
        offer(32'h00200193, 32'h204);
        tick();
        offer(32'h00300213, 32'h208);
        tick();
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("stall_count", emerged.size(), 3);
        if (emerged.size() == 3) begin
            check("stall_order0", emerged[0], 32'h200);
            check("stall_order1", emerged[1], 32'h204);
            check("stall_order2", emerged[2], 32'h208);
        end

        // flush with both entries full and input offered
        emerged.delete();
        out_ready = 1'b0;
        offer(32'h00500293, 32'h300);
        tick();
        offer(32'h00600313, 32'h304);
        tick();
        offer(32'h00700393, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        repeat (3) tick();
        check("flush_none_emerged", emerged.size(), 0);

        // asynchronous reset mid-stream with both entries full
        out_ready = 1'b0;
        offer(32'h00800413, 32'h400);
        tick();
        offer(32'h00900493, 32'h404);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out_instr", out_instr, '0);
        check("mrst_out_pc", out_pc, 32'h0);
        check("mrst_in_ready", in_ready, 1'b0);
        model_q.delete();
        emerged.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("mrst_none_emerged", emerged.size(), 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
